dp_ram_port_arbiter: RTL
========================

# dp_ram_port_arbiter

Round-robin arbiter and sequencer that shares one port of a `dp_ram` between `NUM_REQ` requesters in a single clock domain. It accepts one command at a time, drives the RAM port for one access cycle, and returns read data to the originating requester. If a write collides with the other RAM port (`ARBITRATION_ERR`), the block retries the write up to `MAX_RETRY` times, then reports an error. It sits between requester logic and RAM port B, the port whose writes are blocked on collision.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 8: data width; must match the RAM.
- `DEPTH`, default 8: RAM depth; `AW = $clog2(DEPTH)`.
- `STRB_WIDTH`, default 8: strobe granularity; `WEN = WIDTH/STRB_WIDTH`.
- `MAX_RETRY`, default 3: extra ACCESS cycles allowed after a collision; `RW = $clog2(MAX_RETRY+1)`.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  reset: synchronous, active-high.
- `REQ_VALID`  in  NUM_REQ  per-requester command valid.
- `REQ_READY`  out  NUM_REQ  one-hot acceptance pulse.
- `REQ_ADDR`  in  NUM_REQ*AW  packed addresses; requester i at `[i*AW +: AW]`.
- `REQ_WDATA`  in  NUM_REQ*WIDTH  packed write data.
- `REQ_WEN`  in  NUM_REQ*WEN  packed strobes; all-zero means read.
- `RSP_VALID`  out  NUM_REQ  one-hot response pulse.
- `RSP_RDATA`  out  WIDTH  response data.
- `RSP_ERR`  out  1  write dropped after retries exhausted.
- `RAM_ADDR`  out  AW  to RAM `ADDR_B`.
- `RAM_W_DATA`  out  WIDTH  to `W_DATA_B`.
- `RAM_W_EN`  out  WEN  to `W_EN_B`.
- `RAM_R_DATA`  in  WIDTH  from `R_DATA_B`; combinational read.
- `RAM_ARB_ERR`  in  1  from `ARBITRATION_ERR`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **Arbitration**
  - Runs in IDLE and RESP.
  - The winner is the first requester with `REQ_VALID` set, searching from `last_grant+1` upward with wrap-around.
  - `REQ_READY[winner]` asserts combinationally in that cycle; the handshake completes when valid and ready are both high.
  - On acceptance, latch addr/wdata/wen and the id into the command register, set `last_grant = winner`, clear the retry counter, and go to ACCESS.
  - In RESP with no valid request, go to IDLE. In IDLE with no valid request, stay in IDLE.
- **ACCESS**
  - `RAM_ADDR`, `RAM_W_DATA` and `RAM_W_EN` come from the command register.
  - At the closing edge, capture `RAM_R_DATA`. A write therefore returns the pre-write content of its address.
  - If the command is a write and `RAM_ARB_ERR=1`:
    - retry counter < `MAX_RETRY`: increment it and stay in ACCESS.
    - otherwise: set the error flag and go to RESP.
  - In all other cases, go to RESP with the error flag cleared.
  - `RAM_ARB_ERR` is ignored for reads.
- **RESP**
  - `RSP_VALID[id]=1` for exactly one cycle.
  - `RSP_RDATA` and `RSP_ERR` are valid only while `RSP_VALID` is set.
- **Outside ACCESS**
  - `RAM_W_EN=0`.
  - `RAM_ADDR` and `RAM_W_DATA` hold their last values.
- `REQ_*` inputs of non-accepted requesters are ignored. Requesters must hold their command until they see ready.

## Timing
- **Reset** (on the edge where `RST=1`):
  - FSM goes to IDLE; all registers and outputs return to 0.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - `RAM_W_EN` is gated combinationally by `~RST`, so no write commits on any edge where `RST=1`.
  - An in-flight command is dropped with no response.
- **Latency**
  - Accept at cycle n, ACCESS at n+1, `RSP_VALID` at n+2, plus one cycle per retry.
- **Throughput**
  - One command every 2 cycles, since RESP overlaps the next acceptance.
- **Fairness**
  - With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
  - Maximum wait is NUM_REQ grants.
- **Simultaneous events**
  - A new acceptance in RESP does not disturb the current response outputs.
  - `REQ_VALID` dropping in the same cycle as ready is still an acceptance.
- **Retry bound**
  - A write occupies at most `MAX_RETRY+1` ACCESS cycles.

## Test plan
- **Reset:** hold `RST=1` for 2 cycles with all `REQ_VALID=1`.
  - Required: `REQ_READY`, `RSP_VALID`, `RAM_W_EN`, `RAM_ADDR`, `RSP_RDATA` and `RSP_ERR` are all 0.
  - After release: first grant goes to requester 0.
- **Write then read:** requester 1 writes addr 3, data 0xA5, wen 1.
  - Ready at n; `RAM_W_EN=1` at n+1; `RSP_VALID[1]` at n+2 with `RSP_RDATA=0x00`.
  - A following read of addr 3 returns 0xA5 with `RSP_ERR=0`.
- **Round-robin:** all 4 requesters valid from reset, each issuing reads.
  - Ready pulses go to 0,1,2,3 at cycles n, n+2, n+4, n+6.
  - `RSP_VALID` follows 2 cycles after each ready.
- **Collision retry:** write with `RAM_ARB_ERR=1` for the first 2 ACCESS cycles.
  - 3 ACCESS cycles occur; response arrives at n+4 with `RSP_ERR=0`.
  - With `RAM_ARB_ERR` held at 1 (`MAX_RETRY=3`): 4 ACCESS cycles occur, then a response with `RSP_ERR=1`.
  - A read under `RAM_ARB_ERR=1` completes at n+2.
- **Strobes:** `WIDTH=16`, `STRB_WIDTH=8`; write 0xBEEF with wen 2'b10 over 0x1234.
  - `RAM_W_EN=2'b10`; a later read returns 0xBE34.
- **Reset mid-operation:** assert `RST` during the ACCESS cycle of a write.
  - No RAM write commits, no `RSP_VALID` is issued, the FSM returns to IDLE, and the next grant goes to requester 0.

Source files
------------

// File: rtl/dp_ram_port_arbiter_if.sv
// Requester command/response bus and RAM port-B bus of dp_ram_port_arbiter.
// slave: arbiter side; master: requesters plus the RAM.
interface dp_ram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int STRB_WIDTH = 8
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WEN = WIDTH / STRB_WIDTH;

  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [NUM_REQ-1:0]       REQ_READY;
  logic [NUM_REQ*AW-1:0]    REQ_ADDR;
  logic [NUM_REQ*WIDTH-1:0] REQ_WDATA;
  logic [NUM_REQ*WEN-1:0]   REQ_WEN;
  logic [NUM_REQ-1:0]       RSP_VALID;
  logic [WIDTH-1:0]         RSP_RDATA;
  logic                     RSP_ERR;
  logic [AW-1:0]            RAM_ADDR;
  logic [WIDTH-1:0]         RAM_W_DATA;
  logic [WEN-1:0]           RAM_W_EN;
  logic [WIDTH-1:0]         RAM_R_DATA;
  logic                     RAM_ARB_ERR;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WEN,
    input  RAM_R_DATA, RAM_ARB_ERR,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output RAM_ADDR, RAM_W_DATA, RAM_W_EN
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WEN,
    output RAM_R_DATA, RAM_ARB_ERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  RAM_ADDR, RAM_W_DATA, RAM_W_EN
  );
endinterface

// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing dp_ram port B among NUM_REQ requesters.
// Ports: CLK, RST (sync, active-high), bus (requester + RAM signals, slave).
module dp_ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int STRB_WIDTH = 8,
  parameter int MAX_RETRY  = 3
) (
  input logic                  CLK,
  input logic                  RST,
  dp_ram_port_arbiter_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WEN = WIDTH / STRB_WIDTH;
  localparam int IW  = $clog2(NUM_REQ);
  localparam int RW  =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP
  } state_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WEN-1:0]   wen;
    logic [IW-1:0]    id;
  } cmd_t;

  state_t             state;
  cmd_t               cmd;
  logic [IW-1:0]      last_grant;
  logic [RW-1:0]      retry_cnt;
  logic [WIDTH-1:0]   rdata_q;
  logic               err_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  cmd_t               req_cmd [NUM_REQ];
  logic               found;
  logic [IW-1:0]      winner;
  logic               arb_en;
  logic               collide;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_cmd[i] = '{
      addr:  bus.REQ_ADDR[i*AW +: AW],
      wdata: bus.REQ_WDATA[i*WIDTH +: WIDTH],
      wen:   bus.REQ_WEN[i*WEN +: WEN],
      id:    IW'(i)
    };
  end

  // First valid requester after last_grant, wrapping.
  always_comb begin : arb_search
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.REQ_VALID[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign arb_en  = (state == IDLE) || (state == RESP);
  assign collide = (|cmd.wen) && bus.RAM_ARB_ERR;

  assign bus.REQ_READY =
    (arb_en && found && !RST) ?
    (NUM_REQ'(1) << winner) : '0;

  assign bus.RAM_ADDR   = cmd.addr;
  assign bus.RAM_W_DATA = cmd.wdata;
  // Gated by RST so no write can land on a reset edge.
  assign bus.RAM_W_EN   =
    (state == ACCESS && !RST) ? cmd.wen : '0;

  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cmd         <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      retry_cnt   <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state)
        IDLE, RESP: begin
          if (found) begin
            cmd        <= req_cmd[winner];
            last_grant <= winner;
            retry_cnt  <= '0;
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          rdata_q <= bus.RAM_R_DATA;
          if (collide && retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
          end else begin
            err_q       <= collide;
            rsp_valid_q <= NUM_REQ'(1) << cmd.id;
            state       <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
